sand_grid_vga: RTL

- Avalon-MM VGA peripheral that scans out a GRID_W x GRID_H cell grid for the falling-sand display.
- Each cell holds a CELL_BITS palette index; each cell is upscaled to 2^SCALE_X_LOG2 x 2^SCALE_Y_LOG2 hcount/vcount units.
- The host fills the grid through an auto-incrementing pointer and programs a 24-bit palette.
- An internal FSM clears the grid after reset or on request; a 2-stage scan-out pipeline drives the DAC.

---
 rtl/sand_pkg.sv | 41 ++++
 rtl/vga_timing.sv | 38 +++
 rtl/sand_grid_vga.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sand_pkg.sv
// Shared definitions for the falling-sand VGA grid peripheral: register map,
// 640x480@60 timing (hcount counts 50 MHz ticks, two per pixel), colour type, clear FSM states.
package sand_pkg;

   localparam logic [3:0] REG_PTR_LO  = 4'd0;
   localparam logic [3:0] REG_PTR_HI  = 4'd1;
   localparam logic [3:0] REG_CELL    = 4'd2;
   localparam logic [3:0] REG_PAL_IDX = 4'd3;
   localparam logic [3:0] REG_PAL_R   = 4'd4;
   localparam logic [3:0] REG_PAL_G   = 4'd5;
   localparam logic [3:0] REG_PAL_B   = 4'd6;
   localparam logic [3:0] REG_CTRL    = 4'd7;
   localparam logic [3:0] REG_STATUS  = 4'd8;
   localparam logic [3:0] REG_FRAME   = 4'd9;
   localparam logic [3:0] REG_CUR_X   = 4'd10;
   localparam logic [3:0] REG_CUR_Y   = 4'd11;

   localparam int unsigned H_ACTIVE = 1280;
   localparam int unsigned H_FP     = 32;
   localparam int unsigned H_SYNC   = 192;
   localparam int unsigned H_BP     = 96;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } clr_state_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running 640x480@60 raster counters and undelayed sync/blank strobes.
module vga_timing
   import sand_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [10:0] hcount,
   output logic [9:0]  vcount,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic        vga_clk,
   output logic        end_of_field
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == 11'(H_TOTAL - 1)) begin
         hcount <= '0;
         vcount <= (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
      end else begin
         hcount <= hcount + 11'd1;
      end
   end

   always_comb begin
      hsync        = !((hcount >= 11'(H_ACTIVE + H_FP)) &&
                       (hcount <  11'(H_ACTIVE + H_FP + H_SYNC)));
      vsync        = !((vcount >= 10'(V_ACTIVE + V_FP)) &&
                       (vcount <  10'(V_ACTIVE + V_FP + V_SYNC)));
      blank_n      = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
      vga_clk      = hcount[0];
      end_of_field = (hcount == 11'(H_TOTAL - 1)) && (vcount == 10'(V_TOTAL - 1));
   end

endmodule

// File: rtl/sand_grid_vga.sv
// Avalon-MM falling-sand grid display: cell RAM, palette, clear FSM, 2-stage scan-out.
// Optional 3x3 cell cursor overlay when SAND_CURSOR_EN is defined.
module sand_grid_vga
   import sand_pkg::*;
#(
   parameter int unsigned GRID_W       = 160,
   parameter int unsigned GRID_H       = 120,
   parameter int unsigned CELL_BITS    = 3,
   parameter int unsigned SCALE_X_LOG2 = 3,
   parameter int unsigned SCALE_Y_LOG2 = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       chipselect,
   input  logic       write,
   input  logic       read,
   input  logic [3:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_n,
   output logic       VGA_SYNC_n
);

   localparam int unsigned CELLS = GRID_W * GRID_H;
   localparam int unsigned PTR_W = $clog2(CELLS);
   localparam int unsigned PAL_N = 2 ** CELL_BITS;

   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hs_raw, vs_raw, blank_raw, vclk_raw, end_of_field;

   vga_timing u_timing (
      .clk          (clk),
      .reset        (reset),
      .hcount       (hcount),
      .vcount       (vcount),
      .hsync        (hs_raw),
      .vsync        (vs_raw),
      .blank_n      (blank_raw),
      .vga_clk      (vclk_raw),
      .end_of_field (end_of_field)
   );

   clr_state_t           state, state_nx;
   logic [PTR_W-1:0]     clr_cnt, ptr, wr_addr, rd_addr;
   logic [CELL_BITS-1:0] wr_data, ram_q, pix_idx, pal_idx;
   logic [CELL_BITS-1:0] cell_ram [CELLS];
   rgb_t                 palette [PAL_N];
   rgb_t                 rgb;
   logic                 busy, wr_en, host_wr, cell_wr, clr_req, ptr_ok, enable, vblank;
   logic [7:0]           frame, rd_mux;
   logic [10:0]          col;
   logic [9:0]           row;
   logic                 in_grid;
   logic [1:0]           hs_d, vs_d, blank_d, vclk_d;

   always_comb begin
      host_wr = chipselect && write;
      cell_wr = host_wr && (address == REG_CELL);
      clr_req = host_wr && (address == REG_CTRL) && writedata[1];
      ptr_ok  = 32'(ptr) < CELLS;
      vblank  = vcount >= 10'(V_ACTIVE);
   end

   // Clear FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_CLEAR;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (clr_req) state_nx = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == PTR_W'(CELLS - 1)) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Port A: the clear sweep owns the write port; host cell writes are dropped meanwhile.
   always_comb begin
      busy    = (state == ST_CLEAR);
      wr_en   = 1'b0;
      wr_addr = clr_cnt;
      wr_data = '0;
      if (busy) begin
         wr_en = 1'b1;
      end else if (cell_wr && ptr_ok) begin
         wr_en   = 1'b1;
         wr_addr = ptr;
         wr_data = writedata[CELL_BITS-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                clr_cnt <= '0;
      else if (state == ST_CLEAR)
         clr_cnt <= (clr_cnt == PTR_W'(CELLS - 1)) ? '0 : clr_cnt + PTR_W'(1);
      else                      clr_cnt <= '0;
   end

`ifdef SAND_CURSOR_EN
   logic [7:0] cur_x, cur_y;
   logic       cur_near, cur_hit;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr     <= '0;
         pal_idx <= '0;
         enable  <= 1'b1;
         frame   <= '0;
         for (int unsigned i = 0; i < PAL_N; i++) palette[i] <= '0;
         palette[1] <= '{r: 8'hC2, g: 8'hB2, b: 8'h80};
`ifdef SAND_CURSOR_EN
         cur_x <= '0;
         cur_y <= '0;
`endif
      end else begin
         if (host_wr) begin
            case (address)
               REG_PTR_LO:  ptr[7:0] <= writedata;
               REG_PTR_HI:  ptr[PTR_W-1:8] <= writedata[PTR_W-9:0];
               REG_CELL:    if (!busy) ptr <= (ptr == PTR_W'(CELLS - 1)) ? '0 : ptr + PTR_W'(1);
               REG_PAL_IDX: pal_idx <= writedata[CELL_BITS-1:0];
               REG_PAL_R:   palette[pal_idx].r <= writedata;
               REG_PAL_G:   palette[pal_idx].g <= writedata;
               REG_PAL_B:   palette[pal_idx].b <= writedata;
               REG_CTRL:    enable <= writedata[0];
`ifdef SAND_CURSOR_EN
               REG_CUR_X:   cur_x <= writedata;
               REG_CUR_Y:   cur_y <= writedata;
`endif
               default: ;
            endcase
         end
         if (end_of_field) frame <= frame + 8'd1;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         REG_PTR_LO:  rd_mux = ptr[7:0];
         REG_PTR_HI:  rd_mux = 8'(ptr[PTR_W-1:8]);
         REG_PAL_IDX: rd_mux = 8'(pal_idx);
         REG_PAL_R:   rd_mux = palette[pal_idx].r;
         REG_PAL_G:   rd_mux = palette[pal_idx].g;
         REG_PAL_B:   rd_mux = palette[pal_idx].b;
         REG_CTRL:    rd_mux = {7'd0, enable};
         REG_STATUS:  rd_mux = {6'd0, vblank, busy};
         REG_FRAME:   rd_mux = frame;
`ifdef SAND_CURSOR_EN
         REG_CUR_X:   rd_mux = cur_x;
         REG_CUR_Y:   rd_mux = cur_y;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   readdata <= '0;
      else if (chipselect && read) readdata <= rd_mux;
   end

   // Stage 0: cell address from the raster position
   always_comb begin
      col     = hcount >> SCALE_X_LOG2;
      row     = vcount >> SCALE_Y_LOG2;
      in_grid = blank_raw && (32'(col) < GRID_W) && (32'(row) < GRID_H);
      rd_addr = in_grid ? PTR_W'(32'(row) * GRID_W + 32'(col)) : '0;
   end

   // Stage 1: simple dual-port RAM, read-during-write returns old data
   always_ff @(posedge clk) begin
      if (wr_en) cell_ram[wr_addr] <= wr_data;
      ram_q <= cell_ram[rd_addr];
   end

`ifdef SAND_CURSOR_EN
   always_comb begin
      cur_near = in_grid
         && (12'(col) + 12'd1 >= 12'(cur_x)) && (12'(col) <= 12'(cur_x) + 12'd1)
         && (12'(row) + 12'd1 >= 12'(cur_y)) && (12'(row) <= 12'(cur_y) + 12'd1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_hit <= 1'b0;
      else       cur_hit <= cur_near;
   end

   always_comb pix_idx = cur_hit ? '1 : ram_q;
`else
   always_comb pix_idx = ram_q;
`endif

   // Stage 2: palette lookup; controls ride a matching 2-deep delay line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_d    <= 2'b11;
         vs_d    <= 2'b11;
         blank_d <= '0;
         vclk_d  <= '0;
         rgb     <= '0;
      end else begin
         hs_d    <= {hs_d[0], hs_raw};
         vs_d    <= {vs_d[0], vs_raw};
         blank_d <= {blank_d[0], blank_raw};
         vclk_d  <= {vclk_d[0], vclk_raw};
         rgb     <= (blank_d[0] && enable) ? palette[pix_idx] : '0;
      end
   end

   always_comb begin
      VGA_R       = rgb.r;
      VGA_G       = rgb.g;
      VGA_B       = rgb.b;
      VGA_HS      = hs_d[1];
      VGA_VS      = vs_d[1];
      VGA_BLANK_n = blank_d[1];
      VGA_CLK     = vclk_d[1];
      VGA_SYNC_n  = 1'b0;
   end

endmodule
